// File: rtl/my_pio_pkg.sv
// Shared definitions for the PIO blocks: register word addresses and EDGESEL layout.
package my_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_EDGESEL = 2'd3;

    localparam int         EDGESEL_RISE_BIT = 0;
    localparam int         EDGESEL_FALL_BIT = 1;
    localparam int         EDGESEL_W        = 2;
    localparam logic [1:0] EDGESEL_RESET    = 2'b01;

endpackage

// File: rtl/my_pio_in_filter.sv
// One input bit: SYNC_STAGES-deep synchronizer followed, when MY_PIO_IN_DEBOUNCE_EN
// is defined, by a counter that only accepts values stable for DEBOUNCE_CYCLES samples.
module my_pio_in_filter #(
    parameter int SYNC_STAGES = 2
`ifdef MY_PIO_IN_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

`ifdef MY_PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             filt_reg;

    // Count consecutive samples that disagree with filt; any agreeing sample restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
        end else if (sync_out != filt_reg) begin
            if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_reg <= sync_out;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    assign filt = filt_reg;
`else
    assign filt = sync_out;
`endif

endmodule

// File: rtl/my_pio_in.sv
// Avalon-MM parallel input port with sticky edge capture and masked level interrupt.
// Build option: define MY_PIO_IN_DEBOUNCE_EN to add per-bit debounce after the synchronizer.
module my_pio_in
    import my_pio_pkg::*;
#(
    parameter int INPUT_WIDTH     = 16,
    parameter int MEMORY_WIDTH    = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                avs_address,
    input  logic [MEMORY_WIDTH/8-1:0] avs_byteenable,
    input  logic                      avs_write_n,
    input  logic [MEMORY_WIDTH-1:0]   avs_writedata,
    input  logic                      avs_chipselect,
    input  logic                      avs_read_n,
    output logic [MEMORY_WIDTH-1:0]   avs_readdata,
    output logic                      ins_irq,
    input  logic [INPUT_WIDTH-1:0]    ci_in_port
);

    genvar gi;

    if (INPUT_WIDTH > MEMORY_WIDTH || (MEMORY_WIDTH % 8) != 0 ||
        SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("my_pio_in: illegal parameter combination");
    end

    logic [INPUT_WIDTH-1:0]  filt;
    logic [INPUT_WIDTH-1:0]  prev_reg;
    logic [INPUT_WIDTH-1:0]  edgecap_reg, edgecap_next;
    logic [INPUT_WIDTH-1:0]  irqmask_reg, irqmask_next;
    logic [EDGESEL_W-1:0]    edgesel_reg;
    logic                    irq_reg;
    logic [MEMORY_WIDTH-1:0] readdata_reg, read_mux;
    logic [MEMORY_WIDTH-1:0] lane_mask;
    logic [INPUT_WIDTH-1:0]  wr_mask, wr_data, rise, fall, clear;
    logic                    wr_en, rd_en;

    for (gi = 0; gi < INPUT_WIDTH; gi++) begin : g_bit
        my_pio_in_filter #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef MY_PIO_IN_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_filter (
            .clk   (clk),
            .reset (reset),
            .din   (ci_in_port[gi]),
            .filt  (filt[gi])
        );
    end

    for (gi = 0; gi < MEMORY_WIDTH / 8; gi++) begin : g_lane
        assign lane_mask[gi*8 +: 8] = {8{avs_byteenable[gi]}};
    end

    assign wr_en   = avs_chipselect && !avs_write_n;
    assign rd_en   = avs_chipselect && !avs_read_n;
    assign wr_mask = lane_mask[INPUT_WIDTH-1:0];
    assign wr_data = avs_writedata[INPUT_WIDTH-1:0];
    assign rise    = filt & ~prev_reg;
    assign fall    = ~filt & prev_reg;

    always_comb begin
        clear        = '0;
        irqmask_next = irqmask_reg;
        if (wr_en && avs_address == ADDR_EDGECAP) begin
            clear = wr_data & wr_mask;
        end
        if (wr_en && avs_address == ADDR_IRQMASK) begin
            irqmask_next = (irqmask_reg & ~wr_mask) | (wr_data & wr_mask);
        end
        // New edges are OR-ed in after the clear so a coincident edge keeps its flag.
        edgecap_next = (edgecap_reg & ~clear)
                     | (rise & {INPUT_WIDTH{edgesel_reg[EDGESEL_RISE_BIT]}})
                     | (fall & {INPUT_WIDTH{edgesel_reg[EDGESEL_FALL_BIT]}});
    end

    always_comb begin
        read_mux = '0;
        case (avs_address)
            ADDR_DATA:    read_mux[INPUT_WIDTH-1:0] = filt;
            ADDR_IRQMASK: read_mux[INPUT_WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: read_mux[INPUT_WIDTH-1:0] = edgecap_reg;
            ADDR_EDGESEL: read_mux[EDGESEL_W-1:0]   = edgesel_reg;
            default:      read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg     <= '0;
            edgecap_reg  <= '0;
            irqmask_reg  <= '0;
            edgesel_reg  <= EDGESEL_RESET;
            irq_reg      <= 1'b0;
            readdata_reg <= '0;
        end else begin
            prev_reg    <= filt;
            edgecap_reg <= edgecap_next;
            irqmask_reg <= irqmask_next;
            irq_reg     <= |(edgecap_reg & irqmask_reg);
            if (wr_en && avs_address == ADDR_EDGESEL && avs_byteenable[0]) begin
                edgesel_reg <= avs_writedata[EDGESEL_W-1:0];
            end
            if (rd_en) begin
                readdata_reg <= read_mux;
            end
        end
    end

    assign avs_readdata = readdata_reg;
    assign ins_irq      = irq_reg;

endmodule
